// File: rtl/mpc_dense_constraint_input_bounds.sv
// Writes the input-bound margins u_max-u_prev / u_prev-u_min into h[H_OFFSET..H_OFFSET+2*HORIZON-1].
// Optional build macro MPC_HBOUND_SAT_EN clamps each difference to the DW-bit range instead of wrapping.
module mpc_dense_constraint_input_bounds #(
  parameter int H_OFFSET = 6,
  parameter int HORIZON  = 6,
  parameter int DW       = 21
) (
  input  logic          ap_clk,
  input  logic          ap_rst,
  input  logic          ap_start,
  output logic          ap_done,
  output logic          ap_idle,
  output logic          ap_ready,
  input  logic [DW-1:0] u_max,
  input  logic [DW-1:0] u_min,
  input  logic [DW-1:0] u_prev,
  output logic [4:0]    h_address0,
  output logic          h_ce0,
  output logic          h_we0,
  output logic [DW-1:0] h_d0
);

  localparam int IW = (2 * HORIZON > 1) ? $clog2(2 * HORIZON) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(2 * HORIZON - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [DW-1:0] upper_q, lower_q;
  logic [4:0]    addr_q;
  logic [DW-1:0] data_q;

  logic [DW:0]   diff_upper, diff_lower;
  logic [DW-1:0] upper_new, lower_new;

  assign diff_upper = {u_max[DW-1], u_max} - {u_prev[DW-1], u_prev};
  assign diff_lower = {u_prev[DW-1], u_prev} - {u_min[DW-1], u_min};

`ifdef MPC_HBOUND_SAT_EN
  // A disagreement between the two top bits means the DW+1-bit result left the DW-bit range.
  function automatic logic [DW-1:0] reduce(input logic [DW:0] v);
    if (v[DW] != v[DW-1])
      return v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    return v[DW-1:0];
  endfunction

  assign upper_new = reduce(diff_upper);
  assign lower_new = reduce(diff_lower);
`else
  logic unused_diff_msb;

  assign upper_new       = diff_upper[DW-1:0];
  assign lower_new       = diff_lower[DW-1:0];
  assign unused_diff_msb = diff_upper[DW] ^ diff_lower[DW];
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ap_start) state_d = RUN;
      RUN:     if (idx_q == IDX_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address and data are registered one step ahead so they are valid in the same cycle as we.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      upper_q <= '0;
      lower_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (ap_start) begin
            upper_q <= upper_new;
            lower_q <= lower_new;
            idx_q   <= '0;
            addr_q  <= 5'(H_OFFSET);
            data_q  <= upper_new;
          end
        end
        RUN: begin
          if (idx_q != IDX_LAST) begin
            idx_q  <= idx_q + 1'b1;
            addr_q <= addr_q + 5'd1;
            data_q <= idx_q[0] ? upper_q : lower_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign ap_idle    = (state_q == IDLE);
  assign ap_done    = (state_q == DONE);
  assign ap_ready   = (state_q == DONE);
  assign h_ce0      = (state_q == RUN);
  assign h_we0      = (state_q == RUN);
  assign h_address0 = addr_q;
  assign h_d0       = data_q;

endmodule

// File: tb/tb_mpc_dense_constraint_input_bounds.sv
// Self-checking bench: vector table plus write scoreboard, with hand sequences for hold, reset and horizon=13.
module tb_mpc_dense_constraint_input_bounds;

  localparam int DW = 21;
  localparam int H_OFFSET = 6;
  localparam int HORIZON = 6;
  localparam int NW = 2 * HORIZON;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ap_start = 1'b0;
  logic          ap_done, ap_idle, ap_ready;
  logic [DW-1:0] u_max = '0, u_min = '0, u_prev = '0;
  logic [4:0]    h_address0;
  logic          h_ce0, h_we0;
  logic [DW-1:0] h_d0;

  logic          start13 = 1'b0;
  logic          done13, idle13, ready13;
  logic [4:0]    addr13;
  logic          ce13, we13;
  logic [DW-1:0] d13;

  mpc_dense_constraint_input_bounds #(.H_OFFSET(H_OFFSET), .HORIZON(HORIZON), .DW(DW)) dut (
    .ap_clk(clk), .ap_rst(rst), .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
    .ap_ready(ap_ready), .u_max(u_max), .u_min(u_min), .u_prev(u_prev),
    .h_address0(h_address0), .h_ce0(h_ce0), .h_we0(h_we0), .h_d0(h_d0)
  );

  mpc_dense_constraint_input_bounds #(.H_OFFSET(6), .HORIZON(13), .DW(DW)) dut13 (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start13), .ap_done(done13), .ap_idle(idle13),
    .ap_ready(ready13), .u_max(u_max), .u_min(u_min), .u_prev(u_prev),
    .h_address0(addr13), .h_ce0(ce13), .h_we0(we13), .h_d0(d13)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  typedef struct {
    int umax;
    int umin;
    int uprev;
    int eu;
    int el;
    bit perturb;
  } vec_t;

  wr_t  sb[$];
  bit   sb_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (sb_en && h_we0) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_write", 1, 0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", int'(h_address0), e.addr);
        check("wr_data", int'($signed(h_d0)), e.data);
        check("wr_ce", int'(h_ce0), 1);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    u_max  = DW'(v.umax);
    u_min  = DW'(v.umin);
    u_prev = DW'(v.uprev);
    ap_start = 1'b1;
    sb_en = 1'b1;
    @(posedge clk);
    for (int i = 0; i < NW; i++) begin
      wr_t w;
      w.addr = H_OFFSET + i;
      w.data = (i % 2 == 0) ? v.eu : v.el;
      sb.push_back(w);
    end
    #1 ap_start = 1'b0;
    for (int c = 1; c <= NW + 1; c++) begin
      @(negedge clk);
      check("run_we", int'(h_we0), (c <= NW) ? 1 : 0);
      check("run_done", int'(ap_done), (c == NW + 1) ? 1 : 0);
      check("run_ready", int'(ap_ready), (c == NW + 1) ? 1 : 0);
      check("run_idle", int'(ap_idle), 0);
      if (v.perturb && c == 3) u_prev = '0;
    end
    @(negedge clk);
    check("post_idle", int'(ap_idle), 1);
    check("post_done", int'(ap_done), 0);
    check("sb_drained", sb.size(), 0);
    sb_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1000, -1000, 200, 800, 1200, 1'b0};
    vecs[1] = '{1000, -1000, 200, 800, 1200, 1'b1};
    vecs[2] = '{-5, -20, -7, 2, 13, 1'b0};
    vecs[3] = '{0, 0, 0, 0, 0, 1'b0};
`ifdef MPC_HBOUND_SAT_EN
    vecs[4] = '{1048575, 0, -1048576, 1048575, -1048576, 1'b0};
    vecs[5] = '{0, 1048575, -1048576, 1048575, -1048576, 1'b0};
`else
    vecs[4] = '{1048575, 0, -1048576, -1, -1048576, 1'b0};
    vecs[5] = '{0, 1048575, -1048576, -1048576, 1, 1'b0};
`endif

    #1;
    check("rst_done", int'(ap_done), 0);
    check("rst_ready", int'(ap_ready), 0);
    check("rst_idle", int'(ap_idle), 1);
    check("rst_ce", int'(h_ce0), 0);
    check("rst_we", int'(h_we0), 0);
    check("rst_addr", int'(h_address0), 0);
    check("rst_data", int'(h_d0), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // ap_start held high: period of 14 cycles (12 writes, DONE, one IDLE).
    @(negedge clk);
    u_max = DW'(1000); u_min = DW'(-1000); u_prev = DW'(200);
    ap_start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      int p;
      @(negedge clk);
      p = (c - 1) % 14;
      check("hold_we", int'(h_we0), (p < NW) ? 1 : 0);
      check("hold_done", int'(ap_done), (p == NW) ? 1 : 0);
      check("hold_idle", int'(ap_idle), (p == NW + 1) ? 1 : 0);
      if (p < NW) begin
        check("hold_addr", int'(h_address0), H_OFFSET + p);
        check("hold_data", int'($signed(h_d0)), (p % 2 == 0) ? 800 : 1200);
      end
    end
    ap_start = 1'b0;
    @(negedge clk);
    check("hold_tail_done", int'(ap_done), 1);
    repeat (2) @(negedge clk);

    // Reset during cycle 5 of a run.
    ap_start = 1'b1;
    @(posedge clk);
    #1 ap_start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("rstrun_we", int'(h_we0), 1);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstrun_we_async", int'(h_we0), 0);
    check("rstrun_idle", int'(ap_idle), 1);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen_done = 0;
      for (int c = 0; c < 15; c++) begin
        @(negedge clk);
        if (ap_done || h_we0) seen_done++;
      end
      check("rstrun_no_done_or_write", seen_done, 0);
    end
    run_vec(vecs[0]);

    // HORIZON = 13: 26 writes ending at address 31, ap_done in cycle 27.
    @(negedge clk);
    start13 = 1'b1;
    @(posedge clk);
    #1 start13 = 1'b0;
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      if (c == 1) check("h13_first_addr", int'(addr13), 6);
      if (c == 26) begin
        check("h13_last_addr", int'(addr13), 31);
        check("h13_last_we", int'(we13), 1);
        check("h13_early_done", int'(done13), 0);
      end
      if (c == 27) begin
        check("h13_done", int'(done13), 1);
        check("h13_done_we", int'(we13), 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mpc_dense_constraint_input_bounds.md
Name: mpc_dense_constraint_input_bounds

Overview:
- Downstream neighbour of the constraint1 copy loop in the dense MPC constraint builder.
- After the first H_OFFSET entries of the constraint RHS vector h are filled, this block fills the input-bound entries from H_OFFSET onward.
- For every horizon step k it writes h[H_OFFSET+2k] = u_max - u_prev (upper margin) and h[H_OFFSET+2k+1] = u_prev - u_min (lower margin).
- Uses the standard ap_start/ap_done/ap_idle/ap_ready block handshake and a single-port h memory write interface.

Parameters:
- H_OFFSET, 6, first h index written; equals the entry count of the preceding copy stage.
- HORIZON, 6, number of horizon steps; 2*HORIZON entries are written. Constraint: H_OFFSET + 2*HORIZON <= 32.
- DW, 21, data width of h entries and of the u inputs; signed two's complement fixed point.

Ports:
- ap_clk  in  1  clock.
- ap_rst  in  1  reset, asynchronous, active-high.
- ap_start  in  1  start request.
- ap_done  out  1  one-cycle completion pulse.
- ap_idle  out  1  high while in IDLE.
- ap_ready  out  1  one-cycle pulse, coincident with ap_done.
- u_max  in  DW  upper input bound, signed.
- u_min  in  DW  lower input bound, signed.
- u_prev  in  DW  previously applied input, signed.
- h_address0  out  5  h write address.
- h_ce0  out  1  h chip enable.
- h_we0  out  1  h write enable.
- h_d0  out  DW  h write data.

Behaviour:
- One clock domain, ap_clk. Reset is asynchronous and active-high on ap_rst.
- Reset state:
  - FSM = IDLE; index counter = 0; margin registers = 0.
  - ap_done = 0, ap_ready = 0, ap_idle = 1.
  - h_ce0 = 0, h_we0 = 0, h_address0 = 0, h_d0 = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ap_idle = 1.
  - When ap_start = 1 at a clock edge: latch upper = u_max - u_prev and lower = u_prev - u_min into registers, clear idx, go to RUN.
  - Later changes on the u inputs have no effect on that run.
- Arithmetic:
  - Each subtraction is computed at DW+1 bits, then reduced to DW bits (see Optional Feature).
- RUN:
  - h_ce0 = h_we0 = 1.
  - h_address0 = H_OFFSET + idx, truncated to 5 bits.
  - h_d0 = upper when idx is even, lower when idx is odd.
  - idx increments each cycle.
  - When idx = 2*HORIZON-1, that write completes and the FSM goes to DONE.
- DONE:
  - ap_done = ap_ready = 1 for exactly one cycle.
  - No memory access.
  - Next state is IDLE.
- Latency:
  - Start accepted at edge 0; writes occur in cycles 1..2*HORIZON; ap_done is asserted in cycle 2*HORIZON+1.
  - With defaults: 12 writes, to addresses 6..17, and ap_done in cycle 13.
- ap_start held high:
  - Ignored in RUN and DONE.
  - If still high in IDLE, a new run starts immediately, giving back-to-back runs with one idle cycle between them.
- Outside RUN, h_ce0 = h_we0 = 0 and h_d0 holds its last value.
- Reset mid-RUN: writes stop in the same cycle (we drops asynchronously), the FSM returns to IDLE, and no ap_done is produced.
- All outputs are derived from registered state only; there is no combinational path from ap_start to any output.

Optional Feature:
- Macro: MPC_HBOUND_SAT_EN.
- Defined: each DW+1-bit difference is clamped to [-2^(DW-1), 2^(DW-1)-1], i.e. [-1048576, 1048575] for DW = 21.
- Undefined: the low DW bits are kept (two's complement wrap); there is no saturation logic.

Test Plan:
- Basic run: u_max = 1000, u_min = -1000, u_prev = 200, pulse ap_start -> writes of 800 at addresses 6, 8, ..., 16 and 1200 at 7, 9, ..., 17, in cycles 1..12; ap_done = ap_ready = 1 in cycle 13 only.
- Input latching: change u_prev to 0 in cycle 3 of a run -> all 12 written values still use u_prev = 200.
- Saturation: u_max = 1048575, u_prev = -1048576 -> upper = 1048575 with MPC_HBOUND_SAT_EN defined; upper = -1 (0x1FFFFF) without it. Also u_min = 1048575, u_prev = -1048576 -> lower = -1048576 with the macro defined.
- ap_start held high for 40 cycles -> back-to-back runs, each of 12 writes, with ap_idle = 1 for exactly one cycle between runs; no write during the DONE cycles.
- Reset in cycle 5 of a run -> h_we0 = 0 immediately, no ap_done. A following ap_start gives a full clean run starting again at address 6.
- Parameter check: HORIZON = 13, H_OFFSET = 6 -> last write at address 31; ap_done in cycle 27.
